// File: rtl/ks_sub8_pipe.sv
// ks_sub8_pipe: pipelined Kogge-Stone subtractor, diff = a - b = a + ~b + 1.
//
// Structure: a preprocess "square" stage, then one prefix level per
// register stage, then a combinational "triangle" stage after the last
// register. The carry-in of 1 is folded into bit 0 of the generate vector.
// The pipeline stalls globally: every stage holds when the output is
// valid and the downstream is not ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears all valid bits)
//   a, b       minuend / subtrahend, WIDTH bits
//   in_valid   a/b valid this cycle
//   in_ready   block accepts a/b this cycle
//   diff       a - b mod 2^WIDTH (0 while out_valid is low)
//   bout       borrow out, 1 iff a < b unsigned
//   ovf        signed overflow
//   out_valid  diff/bout/ovf valid
//   out_ready  downstream accepts the result
module ks_sub8_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LEVELS = $clog2(WIDTH);

  // Stage registers: index 0 is the square stage, index k holds the
  // result of prefix level k. s_p carries the original propagate vector
  // down to the triangle stage.
  logic [WIDTH-1:0] g_p  [0:LEVELS];
  logic [WIDTH-1:0] p_p  [0:LEVELS];
  logic [WIDTH-1:0] s_p  [0:LEVELS];
  logic [LEVELS:0]  vld_p;

  logic [WIDTH-1:0] g_nx [0:LEVELS];
  logic [WIDTH-1:0] p_nx [0:LEVELS];
  logic [WIDTH-1:0] s_nx [0:LEVELS];

  logic             advance;

  // One big-circle level: bits at or above span combine with the bit
  // span positions below; lower bits pass through unchanged.
  function automatic logic [2*WIDTH-1:0] ks_level(input logic [WIDTH-1:0] g,
                                                  input logic [WIDTH-1:0] p,
                                                  input int               span);
    logic [WIDTH-1:0] go;
    logic [WIDTH-1:0] po;
    go = g;
    po = p;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= span) begin
        go[i] = g[i] | (p[i] & g[i-span]);
        po[i] = p[i] & p[i-span];
      end
    end
    return {go, po};
  endfunction

  assign advance   = out_ready | ~vld_p[LEVELS];
  assign in_ready  = advance;
  assign out_valid = vld_p[LEVELS];

  always_comb begin
    // Square stage: b is inverted and cin = 1 is absorbed into bit 0,
    // which makes bit 0 generate whenever either a0 or ~b0 is set.
    g_nx[0]    = a & ~b;
    g_nx[0][0] = a[0] | ~b[0];
    p_nx[0]    = a ^ ~b;
    s_nx[0]    = a ^ ~b;
    for (int k = 1; k <= LEVELS; k++) begin
      {g_nx[k], p_nx[k]} = ks_level(g_p[k-1], p_p[k-1], 1 << (k-1));
      s_nx[k] = s_p[k-1];
    end
  end

  // ---- Stage boundary: valid bits for all stages (reset applies here only)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p <= {vld_p[LEVELS-1:0], in_valid};
    end
  end

  // ---- Stage boundary: data registers for square and prefix levels
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k <= LEVELS; k++) begin
        g_p[k] <= g_nx[k];
        p_p[k] <= p_nx[k];
        s_p[k] <= s_nx[k];
      end
    end
  end

  // ---- Triangle stage: after the last level g_p[LEVELS][i] is the carry
  // out of bit i. Outputs are forced to zero when no result is present,
  // so they read 0 after reset.
  always_comb begin
    diff = '0;
    bout = 1'b0;
    ovf  = 1'b0;
    if (vld_p[LEVELS]) begin
      diff = s_p[LEVELS] ^ {g_p[LEVELS][WIDTH-2:0], 1'b1};
      bout = ~g_p[LEVELS][WIDTH-1];
      ovf  = g_p[LEVELS][WIDTH-2] ^ g_p[LEVELS][WIDTH-1];
    end
  end

endmodule

// File: tb/tb_ks_sub8_pipe.sv
// Testbench for ks_sub8_pipe: an 8-bit instance driven by directed and
// random traffic against a queue-based arithmetic model, plus a 16-bit
// instance exercised with a few directed operations.
module tb_ks_sub8_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a, b, diff;
  logic        in_valid, in_ready, bout, ovf, out_valid, out_ready;

  logic [15:0] a16, b16, diff16;
  logic        in_valid16, in_ready16, bout16, ovf16, out_valid16, out_ready16;

  ks_sub8_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  ks_sub8_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .in_valid(in_valid16), .in_ready(in_ready16),
    .diff(diff16), .bout(bout16), .ovf(ovf16), .out_valid(out_valid16), .out_ready(out_ready16)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  int          qt[$];
  bit          lat_on;
  bit          acc;
  bit          prev_stall;
  logic [9:0]  prev_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {ovf, bout, diff}.
  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, r;
    logic [7:0] d;
    logic bo, ov;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    r  = ux - uy;
    d  = r[7:0];
    bo = (ux < uy);
    ov = ((sx - sy) > 127) || ((sx - sy) < -128);
    return {ov, bo, d};
  endfunction

  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y);
    int ux, uy, sx, sy, r;
    logic [15:0] d;
    logic bo, ov;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    r  = ux - uy;
    d  = r[15:0];
    bo = (ux < uy);
    ov = ((sx - sy) > 32767) || ((sx - sy) < -32768);
    return {ov, bo, d};
  endfunction

  // One clock of the 8-bit instance: drive at the falling edge, then
  // observe the handshake that the next rising edge will perform.
  task automatic step(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                      input logic ordy, input logic r);
    logic [7:0] ea, eb;
    logic [9:0] e;
    int t;
    @(negedge clk);
    cyc++;
    in_valid = iv; a = av; b = bv; out_ready = ordy; rst = r;
    #1;
    acc = 1'b0;
    if (prev_stall && !r) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", {ovf, bout, diff}, prev_out);
    end
    if (r) begin
      qa.delete(); qb.delete(); qt.delete();
    end else begin
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          ea = qa.pop_front(); eb = qb.pop_front(); t = qt.pop_front();
          e  = ref8(ea, eb);
          check("diff", diff, e[7:0]);
          check("bout", bout, e[8]);
          check("ovf", ovf, e[9]);
          if (lat_on) check("latency", cyc - t, 4);
        end
      end
      if (in_valid && in_ready) begin
        qa.push_back(av); qb.push_back(bv); qt.push_back(cyc);
        acc = 1'b1;
      end
    end
    prev_stall = out_valid && !out_ready && !r;
    prev_out   = {ovf, bout, diff};
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("drain_empty", qa.size(), 0);
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y);
    logic [17:0] e;
    int cnt;
    e = ref16(x, y);
    @(negedge clk);
    a16 = x; b16 = y; in_valid16 = 1'b1; out_ready16 = 1'b1;
    #1;
    check("in_ready16", in_ready16, 1);
    @(negedge clk);
    in_valid16 = 1'b0;
    cnt = 1;
    while (!out_valid16 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("latency16", cnt, 5);
    check("diff16", diff16, e[15:0]);
    check("bout16", bout16, e[16]);
    check("ovf16", ovf16, e[17]);
    @(negedge clk);
    check("valid16_pulse", out_valid16, 0);
  endtask

  logic [7:0] dir_a [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [7:0] dir_b [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF};

  initial begin
    int idx, s;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    a16 = '0; b16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b1;
    prev_stall = 1'b0; prev_out = '0; lat_on = 1'b1;

    // Reset and reset-state checks
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst16_out_valid", out_valid16, 0);

    // Directed single operations with latency checking
    for (int i = 0; i < 6; i++) begin
      step(1'b1, dir_a[i], dir_b[i], 1'b1, 1'b0);
      drain(6);
    end

    // Back-to-back stream with a three-cycle downstream stall
    lat_on = 1'b0;
    idx = 0; s = 0;
    while (idx < 16 && s < 100) begin
      step(1'b1, idx[7:0], 8'h01, !(s >= 6 && s <= 8), 1'b0);
      if (acc) idx++;
      s++;
    end
    check("stream_accepted", idx, 16);
    drain(8);

    // Reset with three operations in flight; rst wins over in_valid
    lat_on = 1'b1;
    step(1'b1, 8'h11, 8'h22, 1'b1, 1'b0);
    step(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
    step(1'b1, 8'h55, 8'h66, 1'b1, 1'b0);
    step(1'b1, 8'h77, 8'h88, 1'b1, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h10, 8'h20, 1'b1, 1'b0);
    drain(6);

    // Random traffic with random valid and ready
    lat_on = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 3) != 0, 1'b0);
    end
    drain(12);

    // 16-bit instance
    op16(16'h0000, 16'h0001);
    op16(16'h8000, 16'h0001);
    op16(16'h1234, 16'h1234);
    op16(16'h0000, 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
